// File: rtl/spi_slave.sv
// SPI slave: start bit, LSB-first payload, trailer bit; MISO replies with latched tx_data.
// Define SPI_SLAVE_PARITY_EN to make the trailer even parity instead of a stop bit.
module spi_slave #(
  parameter int package_size = 8
) (
  input  logic                    clk_div,
  input  logic                    rst,
  input  logic                    SS,
  input  logic                    MOSI,
  input  logic [package_size-1:0] tx_data,
  output logic                    MISO,
  output logic [package_size-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int P  = package_size;
  localparam int CW = $clog2(P + 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [P:0]    sr, sr_n;
  logic [P-1:0]  tx_q, tx_n;
  logic [P-1:0]  rxd_n;
  logic          miso_n, rxv_n, err_n;
  logic          last, trl_ok, good, start;

  assign last  = cnt == CW'(P + 1);
  assign start = (state == IDLE || state == DONE) && !SS;
  assign busy  = state != IDLE;

`ifdef SPI_SLAVE_PARITY_EN
  assign trl_ok = (^sr[P:1]) == MOSI;
`else
  assign trl_ok = MOSI;
`endif

  // sr[0] is the start bit once P+1 bits have been shifted in
  assign good = !sr[0] && trl_ok;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    tx_n    = tx_q;
    miso_n  = MISO;
    rxd_n   = rx_data;
    rxv_n   = 1'b0;
    err_n   = 1'b0;
    if (start) begin
      state_n = SHIFT;
      cnt_n   = CW'(1);
      sr_n    = {MOSI, sr[P:1]};
      tx_n    = tx_data;
      miso_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n  = '0;
          miso_n = 1'b1;
        end
        SHIFT: begin
          if (SS) begin
            state_n = IDLE;
            cnt_n   = '0;
            miso_n  = 1'b1;
            err_n   = 1'b1;
          end else if (last) begin
            state_n = DONE;
            miso_n  = 1'b0;
            if (good) begin
              rxd_n = sr[P:1];
              rxv_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            sr_n   = {MOSI, sr[P:1]};
            miso_n = tx_q[0];
            tx_n   = tx_q >> 1;
            cnt_n  = cnt + 1'b1;
          end
        end
        DONE: begin
          state_n = IDLE;
          cnt_n   = '0;
          miso_n  = 1'b1;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          miso_n  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      tx_q      <= '0;
      MISO      <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sr        <= sr_n;
      tx_q      <= tx_n;
      MISO      <= miso_n;
      rx_data   <= rxd_n;
      rx_valid  <= rxv_n;
      frame_err <= err_n;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized frame-level bench for spi_slave with per-cycle output checking.
// Honours SPI_SLAVE_PARITY_EN the same way the design does.
module tb_spi_slave;

  localparam int P = 8;

  logic         clk_div = 1'b0;
  logic         rst = 1'b1;
  logic         SS = 1'b1;
  logic         MOSI = 1'b0;
  logic [P-1:0] tx_data = '0;
  logic         MISO;
  logic [P-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         busy;

  spi_slave #(.package_size(P)) dut (
    .clk_div  (clk_div),
    .rst      (rst),
    .SS       (SS),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk_div = ~clk_div;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int vq[$];

  logic         e_busy = 1'b0;
  logic         e_miso = 1'b1;
  logic         e_valid = 1'b0;
  logic         e_err = 1'b0;
  logic [P-1:0] e_rxd = '0;
  logic [P+1:0] cap;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_div) begin
    cyc++;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("miso", 32'(MISO), 32'(e_miso));
    chk("rx_valid", 32'(rx_valid), 32'(e_valid));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("rx_data", 32'(rx_data), 32'(e_rxd));
    if (rx_valid === 1'b1) vq.push_back(cyc);
  end

  function automatic logic good_trl(input logic [P-1:0] p);
`ifdef SPI_SLAVE_PARITY_EN
    return ^p;
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick(input logic ss, input logic mosi,
                      input logic [P-1:0] tx);
    SS      = ss;
    MOSI    = mosi;
    tx_data = tx;
    @(posedge clk_div);
    #1;
    e_valid = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'($urandom), P'($urandom));
      e_busy = 1'b0;
      e_miso = 1'b1;
    end
  endtask

  // nbits frame bits are sent; abort raises SS afterwards
  task automatic send_frame(input logic st, input logic [P-1:0] pay,
                            input logic trl, input logic [P-1:0] tx,
                            input int nbits, input bit abort);
    logic [P+1:0] fr;
    fr = {trl, pay, st};
    for (int k = 0; k < nbits; k++) begin
      tick(1'b0, fr[k], (k == 0) ? tx : P'($urandom));
      cap[k] = MISO;
      e_busy = 1'b1;
      if (k == 0 || k == P + 1) e_miso = 1'b0;
      else e_miso = tx[k-1];
      if (k == P + 1) begin
        if (!st && trl == good_trl(pay)) begin
          e_valid = 1'b1;
          e_rxd   = pay;
        end else begin
          e_err = 1'b1;
        end
      end
    end
    if (abort) begin
      tick(1'b1, 1'b0, P'($urandom));
      e_busy = 1'b0;
      e_miso = 1'b1;
      e_err  = 1'b1;
    end
  endtask

  initial begin
    logic [P+1:0] c1, c2;
    logic [P-1:0] pay, tx;
    logic         st, trl;

    repeat (3) @(posedge clk_div);
    #1;
    chk("rst_miso", 32'(MISO), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rxd", 32'(rx_data), 32'h0);
    rst = 1'b0;
    idle(2);

    send_frame(1'b0, 8'hA5, good_trl(8'hA5), 8'h00, P + 2, 1'b0);
    idle(1);
    chk("a5_rxd", 32'(rx_data), 32'hA5);

`ifdef SPI_SLAVE_PARITY_EN
    send_frame(1'b0, 8'hA5, 1'b1, 8'h00, P + 2, 1'b0);
`else
    send_frame(1'b1, 8'h3C, 1'b1, 8'h00, P + 2, 1'b0);
`endif
    idle(1);
    chk("bad_keep_rxd", 32'(rx_data), 32'hA5);

    send_frame(1'b0, 8'hFF, 1'b1, 8'h00, 4, 1'b1);
    chk("abort_busy", 32'(busy), 32'h0);
    send_frame(1'b0, 8'h5A, good_trl(8'h5A), 8'h00, P + 2, 1'b0);
    idle(1);
    chk("5a_rxd", 32'(rx_data), 32'h5A);

    send_frame(1'b0, 8'h77, 1'b1, 8'h00, 6, 1'b0);
    #2;
    rst     = 1'b1;
    e_busy  = 1'b0;
    e_miso  = 1'b1;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_rxd   = '0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_miso", 32'(MISO), 32'h1);
    chk("mid_rst_rxd", 32'(rx_data), 32'h0);
    chk("mid_rst_pulses", 32'({rx_valid, frame_err}), 32'h0);
    @(posedge clk_div);
    #1;
    rst = 1'b0;
    idle(1);
    send_frame(1'b0, 8'h81, good_trl(8'h81), 8'h00, P + 2, 1'b0);
    idle(1);
    chk("81_rxd", 32'(rx_data), 32'h81);

    vq.delete();
    send_frame(1'b0, 8'h11, good_trl(8'h11), 8'h3C, P + 2, 1'b0);
    c1 = cap;
    send_frame(1'b0, 8'h22, good_trl(8'h22), 8'h3C, P + 2, 1'b0);
    c2 = cap;
    idle(1);
    chk("b2b_miso1", 32'(c1), 32'h078);
    chk("b2b_miso2", 32'(c2), 32'h078);
    chk("b2b_rxd", 32'(rx_data), 32'h22);
    chk("b2b_nvalid", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) chk("b2b_gap", 32'(vq[1] - vq[0]), 32'd10);

    for (int i = 0; i < 60; i++) begin
      pay = P'($urandom);
      tx  = P'($urandom);
      st  = ($urandom % 6) == 0;
      trl = good_trl(pay) ^ (($urandom % 6) == 0);
      if (($urandom % 8) == 0)
        send_frame(st, pay, trl, tx, int'($urandom_range(1, P + 1)), 1'b1);
      else
        send_frame(st, pay, trl, tx, P + 2, 1'b0);
      idle(int'($urandom % 3));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
